// File: rtl/mux_2to1.sv
// Two-input mux: combinational out plus registered out_q/sel_q/sel_chg; optional switch counter via MUX2TO1_SWCNT_EN.
// Latency: out zero cycles, registered outputs one cycle. No backpressure: new data and select are accepted every cycle.
module mux_2to1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic             sel_chg
`ifdef MUX2TO1_SWCNT_EN
  ,
  output logic [CNT_W-1:0] sw_cnt
`endif
);

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("mux_2to1: WIDTH must be within 1..1024");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("mux_2to1: CNT_W must be at least 1");
  end

  // Conditional operator keeps agreeing bits when sel is X and X's the rest.
  assign out = sel ? b : a;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q   <= '0;
      sel_q   <= 1'b0;
      sel_chg <= 1'b0;
    end else begin
      out_q   <= out;
      sel_q   <= sel;
      sel_chg <= (sel != sel_q);
    end
  end

`ifdef MUX2TO1_SWCNT_EN
  // Free-running wrap, no saturation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_cnt <= '0;
    end else if (sel != sel_q) begin
      sw_cnt <= sw_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mux_2to1.sv
// Self-checking bench for mux_2to1 (WIDTH=8, CNT_W=2) using an expected-value queue.
module tb_mux_2to1;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       sel;
  logic [7:0] out;
  logic [7:0] out_q;
  logic       sel_q;
  logic       sel_chg;
`ifdef MUX2TO1_SWCNT_EN
  logic [1:0] sw_cnt;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] oq;
    logic       sq;
    logic       chg;
    logic [1:0] cnt;
  } exp_t;

  exp_t       sbq[$];
  logic       m_sel_q = 1'b0;
  logic [1:0] m_cnt = 2'd0;

  mux_2to1 #(.WIDTH(8), .CNT_W(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .sel     (sel),
    .out     (out),
    .out_q   (out_q),
    .sel_q   (sel_q),
    .sel_chg (sel_chg)
`ifdef MUX2TO1_SWCNT_EN
    ,
    .sw_cnt  (sw_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Predict the registered outputs from the inputs present at the coming edge, then take that edge.
  task automatic step();
    exp_t e;
    if (!rst_n) begin
      e = '{oq: 8'h00, sq: 1'b0, chg: 1'b0, cnt: 2'd0};
      m_sel_q = 1'b0;
      m_cnt   = 2'd0;
    end else begin
      e.oq  = sel ? b : a;
      e.chg = (sel != m_sel_q);
      if (e.chg) m_cnt = m_cnt + 2'd1;
      e.sq    = sel;
      e.cnt   = m_cnt;
      m_sel_q = sel;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; sel = 1'b1; a = 8'h00; b = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      step();
      e = sbq.pop_front();
      checks++;
      if ({out_q, sel_q, sel_chg} !== {e.oq, e.sq, e.chg}) begin
        failures++;
        $display("FAIL reset_hold[%0d] got out_q=%h sel_q=%b sel_chg=%b want %h %b %b",
                 i, out_q, sel_q, sel_chg, e.oq, e.sq, e.chg);
      end
      checks++;
      if (out !== 8'hFF) begin
        failures++;
        $display("FAIL reset_comb_out[%0d] got %h want ff", i, out);
      end
    end
    rst_n = 1'b1;
    step();
    e = sbq.pop_front();
    checks++;
    if ({out_q, sel_q, sel_chg} !== {e.oq, e.sq, e.chg} || out_q !== 8'hFF || sel_chg !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got out_q=%h sel_q=%b sel_chg=%b want ff 1 1", out_q, sel_q, sel_chg);
    end
  endtask

  task automatic test_comb();
    a = 8'h00; b = 8'h01; sel = 1'b0;
    #1;
    checks++;
    if (out !== 8'h00) begin
      failures++;
      $display("FAIL comb_sel0 got %h want 00", out);
    end
    sel = 1'b1;
    #1;
    checks++;
    if (out !== 8'h01) begin
      failures++;
      $display("FAIL comb_sel1 got %h want 01", out);
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [2:0] pat;
    logic [7:0] want_q [3];
    pat = 3'b010;
    want_q[0] = 8'h5A; want_q[1] = 8'hA5; want_q[2] = 8'h5A;
    a = 8'h5A; b = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      sel = pat[i];
      step();
      e = sbq.pop_front();
      checks++;
      if ({out_q, sel_q, sel_chg} !== {e.oq, e.sq, e.chg} || out_q !== want_q[i] || sel_chg !== 1'b1) begin
        failures++;
        $display("FAIL b2b[%0d] got out_q=%h sel_q=%b sel_chg=%b want %h %b 1",
                 i, out_q, sel_q, sel_chg, want_q[i], e.sq);
      end
    end
  endtask

  task automatic test_between_edges();
    exp_t e;
    a = 8'h33; b = 8'hCC; sel = 1'b0;
    step();
    e = sbq.pop_front();
    sel = 1'b1;
    #1;
    checks++;
    if (out !== 8'hCC) begin
      failures++;
      $display("FAIL glitch_hi got %h want cc", out);
    end
    sel = 1'b0;
    #1;
    checks++;
    if (out !== 8'h33) begin
      failures++;
      $display("FAIL glitch_lo got %h want 33", out);
    end
    sel = 1'b1;
    step();
    e = sbq.pop_front();
    checks++;
    if ({out_q, sel_q, sel_chg} !== {e.oq, e.sq, e.chg}) begin
      failures++;
      $display("FAIL glitch_reg got out_q=%h sel_q=%b sel_chg=%b want %h %b %b",
               out_q, sel_q, sel_chg, e.oq, e.sq, e.chg);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    a = 8'h5A; b = 8'hA5; sel = 1'b1; rst_n = 1'b1;
    step();
    e = sbq.pop_front();
    checks++;
    if (out_q !== 8'hA5) begin
      failures++;
      $display("FAIL midrst_setup got %h want a5", out_q);
    end
    #2;
    rst_n = 1'b0; sel = 1'b0;
    #1;
    checks++;
    if (out_q !== 8'hA5) begin
      failures++;
      $display("FAIL midrst_hold got %h want a5", out_q);
    end
    step();
    e = sbq.pop_front();
    checks++;
    if ({out_q, sel_q, sel_chg} !== {e.oq, e.sq, e.chg} || out_q !== 8'h00) begin
      failures++;
      $display("FAIL midrst_clear got out_q=%h sel_q=%b sel_chg=%b want 00 0 0", out_q, sel_q, sel_chg);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_swcnt();
    exp_t       e;
    logic [1:0] want_cnt [5];
    want_cnt[0] = 2'd1; want_cnt[1] = 2'd2; want_cnt[2] = 2'd3; want_cnt[3] = 2'd0; want_cnt[4] = 2'd1;
    rst_n = 1'b0; sel = 1'b0;
    step();
    void'(sbq.pop_front());
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sel = ~sel;
      step();
      e = sbq.pop_front();
      checks++;
      if ({out_q, sel_q, sel_chg} !== {e.oq, e.sq, e.chg}) begin
        failures++;
        $display("FAIL swcnt_reg[%0d] got out_q=%h sel_q=%b sel_chg=%b want %h %b %b",
                 i, out_q, sel_q, sel_chg, e.oq, e.sq, e.chg);
      end
`ifdef MUX2TO1_SWCNT_EN
      checks++;
      if (sw_cnt !== e.cnt || sw_cnt !== want_cnt[i]) begin
        failures++;
        $display("FAIL swcnt[%0d] got %0d want %0d", i, sw_cnt, want_cnt[i]);
      end
`endif
    end
  endtask

  task automatic test_sel_x();
    logic [7:0] want;
    logic [7:0] agree;
    a = 8'b0000_1100; b = 8'b0000_1010; sel = 1'bx;
    want  = 8'b0000_1000;
    agree = ~(a ^ b);
    #1;
    checks++;
    if (((out ^ want) & agree) !== 8'h00) begin
      failures++;
      $display("FAIL sel_x got %b want 00001xx0", out);
    end
    sel = 1'b0;
    #1;
  endtask

  task automatic test_random();
    exp_t e;
    for (int i = 0; i < 24; i++) begin
      a     = 8'($urandom);
      b     = 8'($urandom);
      sel   = 1'($urandom);
      rst_n = ($urandom_range(0, 7) != 0);
      #1;
      checks++;
      if (out !== (sel ? b : a)) begin
        failures++;
        $display("FAIL rand_comb[%0d] got %h want %h", i, out, sel ? b : a);
      end
      step();
      e = sbq.pop_front();
      checks++;
      if ({out_q, sel_q, sel_chg} !== {e.oq, e.sq, e.chg}) begin
        failures++;
        $display("FAIL rand_reg[%0d] got out_q=%h sel_q=%b sel_chg=%b want %h %b %b",
                 i, out_q, sel_q, sel_chg, e.oq, e.sq, e.chg);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; a = 8'h00; b = 8'h00; sel = 1'b0;
    test_reset();
    test_comb();
    step();
    void'(sbq.pop_front());
    test_back_to_back();
    test_between_edges();
    test_mid_reset();
    test_swcnt();
    test_sel_x();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
